dcache_sa_wb: RTL and testbench
===============================

Name: dcache_sa_wb

Overview:
- Parametrised N-way set-associative data cache tag/state model with true-LRU replacement and write-back/write-allocate policy.
- Sits between the trace-driven command source and the next-level cache.
- Adds over the previous generation:
  - valid/ready handshakes on both sides;
  - dirty bits with victim writeback;
  - a multi-cycle clear sweep;
  - configurable geometry.
- Tags and state only; no data storage.

Parameters:
- ADDR_W, 32, request address width.
- OFFSET_BITS, 6, log2 of line size in bytes.
- INDEX_BITS, 14, log2 of set count (SETS = 2**INDEX_BITS).
- WAYS, 4, associativity; power of two, minimum 2.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  block can accept a command.
- req_cmd  in  4  0=READ, 1=WRITE, 3=INVALIDATE, 8=CLEAR; other codes are accepted and ignored.
- req_addr  in  ADDR_W  byte address.
- resp_valid  out  1  one-cycle pulse; command completed.
- resp_hit  out  1  with resp_valid: lookup hit.
- l2_valid  out  1  next-level request present.
- l2_ready  in  1  next level accepts.
- l2_wb  out  1  1=writeback of dirty victim, 0=line fill.
- l2_addr  out  ADDR_W-OFFSET_BITS  line address.
- busy  out  1  FSM not in IDLE.
- hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt  out  CNT_W each  statistics.

Behaviour:
- Field split:
  - TAG_W = ADDR_W-INDEX_BITS-OFFSET_BITS;
  - index = req_addr[OFFSET_BITS+:INDEX_BITS];
  - tag = upper bits.
- Per set and way: valid, dirty, tag[TAG_W], age[log2 WAYS].
- Handshake:
  - A command is accepted when req_valid and req_ready are both high; cmd/addr are captured.
  - req_ready is high only in IDLE.
  - l2 transfer occurs on the cycle where l2_valid and l2_ready are both high.
  - l2_valid, l2_wb and l2_addr are held stable until that transfer.
- FSM states: CLEAR, IDLE, LOOKUP, WB, FILL, RESP.
- CLEAR:
  - Clears one set per cycle, starting at set 0:
    - valid=0, dirty=0, tag=0;
    - age[w]=w.
  - Completes after SETS cycles, then goes to IDLE.
- IDLE: accept a command, then go to LOOKUP.
  - CLEAR cmd goes directly to CLEAR and zeroes all counters in the accept cycle.
  - An ignored cmd goes to RESP with resp_hit=0 and no counter change.
- LOOKUP (1 cycle):
  - Hit = valid way with matching tag.
  - READ/WRITE hit: update LRU; WRITE sets dirty; go to RESP with resp_hit=1. Hit latency is resp_valid 2 cycles after accept.
  - READ/WRITE miss: choose a victim. The victim is the lowest-index invalid way, else the way whose age is WAYS-1.
    - Dirty victim: go to WB with l2_addr={victim tag,index}.
    - Clean victim: go to FILL with l2_addr=req line.
  - INVALIDATE hit:
    - Dirty: go to WB, then clear valid and dirty.
    - Clean: clear valid and go to RESP.
    - LRU is not changed.
  - INVALIDATE miss: go to RESP with resp_hit=0.
- WB:
  - On l2 transfer, wb_cnt increments.
  - Next state is FILL, or RESP for INVALIDATE.
- FILL:
  - On l2 transfer, the victim way gets tag, valid=1, dirty=(cmd==WRITE); LRU is updated.
  - Next state is RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- LRU update on an access to way k with old age a:
  - age[k] becomes 0;
  - every way with age<a increments;
  - ages always form a permutation of 0..WAYS-1.
- Counters:
  - read_cnt and write_cnt increment at LOOKUP for their cmd.
  - hit_cnt and miss_cnt increment at LOOKUP for READ/WRITE only; INVALIDATE does not count.
  - All counters saturate at all-ones.
- Reset: asynchronous assertion forces:
  - state=CLEAR, sweep pointer=0;
  - all counters=0;
  - resp_valid=0, resp_hit=0, l2_valid=0, l2_wb=0, l2_addr=0;
  - req_ready=0, busy=1.
  - Arrays are cleared by the sweep after deassertion.
  - Reset mid-transfer abandons the transfer with no l2 handshake completion.
  - req_ready stays low until the sweep finishes.

Optional Feature:
- DCACHE_STATS_EN defined: the five counters are implemented as specified.
- Undefined: the counters are omitted and their outputs are tied to 0; all other behaviour is identical.

Decomposition:
- Shared package dcache_pkg holds:
  - the command code constants (READ, WRITE, INVALIDATE, CLEAR);
  - the FSM state enum;
  - the TAG_W derivation function.
- One sub-module, lru_age_update: combinational; inputs are the age vector and the accessed way; outputs are the new age vector and the victim way. It is parametrised by WAYS.

Test Plan:
- Reset, then hold req_valid: req_ready=0 for exactly SETS cycles after rst_n rises, then 1; all counters read 0.
- READ 0x0000_1040 twice: first miss produces FILL with l2_addr=0x41 and l2_wb=0; second gives resp_hit=1, 2 cycles after accept. Result: hit_cnt=1, miss_cnt=1, read_cnt=2.
- WAYS=4: WRITE to 5 distinct tags mapping to index 0. The 5th evicts the first tag: a WB request (l2_wb=1, old line address) precedes the FILL, and wb_cnt=1.
- Touch ways 0..3 in order, then re-read way 0's tag, then read a new tag: the victim is way 1, confirming the age update.
- INVALIDATE on a dirty line produces WB and then resp_hit=1; a subsequent READ misses. INVALIDATE on an absent tag gives resp_hit=0 and issues no l2 request.
- Hold l2_ready=0 for 10 cycles during FILL: l2_valid and l2_addr stay stable and busy=1. Assert rst_n=0 mid-stall: l2_valid drops immediately and a sweep follows.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative write-back data cache tag/state model:
// command codes, controller state encoding and tag-width derivation.
package dcache_pkg;

  localparam logic [3:0] CMD_READ  = 4'd0;
  localparam logic [3:0] CMD_WRITE = 4'd1;
  localparam logic [3:0] CMD_INVAL = 4'd3;
  localparam logic [3:0] CMD_CLEAR = 4'd8;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL,
    ST_RESP
  } state_e;

  function automatic int tag_width(input int addr_w, input int index_bits, input int offset_bits);
    return addr_w - index_bits - offset_bits;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// True-LRU age update for one set: the accessed way becomes youngest, and the way
// holding the oldest age (WAYS-1) is reported as the replacement candidate.
module lru_age_update #(
  parameter int  WAYS = 4,
  localparam int AW   = $clog2(WAYS)
) (
  input  logic [WAYS*AW-1:0] i_age,
  input  logic [AW-1:0]      i_way,
  output logic [WAYS*AW-1:0] o_age,
  output logic [AW-1:0]      o_victim
);

  logic [AW-1:0] w_acc_age;

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    w_acc_age = '0;
    o_victim  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == i_way) w_acc_age = i_age[w*AW +: AW];
      if (i_age[w*AW +: AW] == AW'(WAYS - 1)) o_victim = AW'(w);
    end
    o_age = i_age;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == i_way) o_age[w*AW +: AW] = '0;
      else if (i_age[w*AW +: AW] < w_acc_age) o_age[w*AW +: AW] = i_age[w*AW +: AW] + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_sa_wb.sv
// N-way set-associative write-back/write-allocate cache tag/state controller with true LRU.
// Statistics counters are built only when DCACHE_STATS_EN is defined; otherwise they read 0.
module dcache_sa_wb
  import dcache_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int WAYS        = 4,
  parameter int CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_cmd,
  input  logic [ADDR_W-1:0]             req_addr,
  output logic                          resp_valid,
  output logic                          resp_hit,
  output logic                          l2_valid,
  input  logic                          l2_ready,
  output logic                          l2_wb,
  output logic [ADDR_W-OFFSET_BITS-1:0] l2_addr,
  output logic                          busy,
  output logic [CNT_W-1:0]              hit_cnt,
  output logic [CNT_W-1:0]              miss_cnt,
  output logic [CNT_W-1:0]              read_cnt,
  output logic [CNT_W-1:0]              write_cnt,
  output logic [CNT_W-1:0]              wb_cnt
);

  localparam int TAG_W  = tag_width(ADDR_W, INDEX_BITS, OFFSET_BITS);
  localparam int SETS   = 2 ** INDEX_BITS;
  localparam int AW     = $clog2(WAYS);
  localparam int LINE_W = ADDR_W - OFFSET_BITS;

  state_e                r_state, w_next;
  logic [3:0]            r_cmd;
  logic [LINE_W-1:0]     r_line;
  logic [INDEX_BITS-1:0] r_sweep;
  logic [AW-1:0]         r_way;
  logic [LINE_W-1:0]     r_l2_addr;
  logic                  r_resp_hit;

  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [WAYS*AW-1:0] r_age   [SETS];

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_accept, w_l2_xfer, w_rw;
  logic                  w_hit, w_inv_found, w_hit_dirty, w_victim_dirty;
  logic [AW-1:0]         w_hit_way, w_inv_way, w_lru_way, w_victim, w_acc_way;
  logic [WAYS*AW-1:0]    w_new_age, w_init_age;
  logic                  w_unused_offset;

  assign w_index         = r_line[INDEX_BITS-1:0];
  assign w_tag           = r_line[LINE_W-1:INDEX_BITS];
  assign w_accept        = (r_state == ST_IDLE) && req_valid;
  assign w_l2_xfer       = l2_valid && l2_ready;
  assign w_rw            = (r_cmd == CMD_READ) || (r_cmd == CMD_WRITE);
  assign w_unused_offset = ^req_addr[OFFSET_BITS-1:0];

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_hit   = (r_state == ST_RESP) && r_resp_hit;
  assign l2_valid   = (r_state == ST_WB) || (r_state == ST_FILL);
  assign l2_wb      = (r_state == ST_WB);
  assign l2_addr    = r_l2_addr;

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_init_age  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AW'(w);
      end
      if (!r_valid[w_index][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = AW'(w);
      end
      w_init_age[w*AW +: AW] = AW'(w);
    end
  end

  assign w_victim       = w_inv_found ? w_inv_way : w_lru_way;
  assign w_victim_dirty = r_valid[w_index][w_victim] && r_dirty[w_index][w_victim];
  assign w_hit_dirty    = r_dirty[w_index][w_hit_way];
  assign w_acc_way      = (r_state == ST_LOOKUP) ? w_hit_way : r_way;

  lru_age_update #(.WAYS(WAYS)) u_lru (
    .i_age    (r_age[w_index]),
    .i_way    (w_acc_way),
    .o_age    (w_new_age),
    .o_victim (w_lru_way)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CLEAR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR:  if (&r_sweep) w_next = ST_IDLE;
      ST_IDLE: if (w_accept) begin
        case (req_cmd)
          CMD_READ, CMD_WRITE, CMD_INVAL: w_next = ST_LOOKUP;
          CMD_CLEAR:                      w_next = ST_CLEAR;
          default:                        w_next = ST_RESP;
        endcase
      end
      ST_LOOKUP: begin
        if (w_rw)       w_next = w_hit ? ST_RESP : (w_victim_dirty ? ST_WB : ST_FILL);
        else if (w_hit) w_next = w_hit_dirty ? ST_WB : ST_RESP;
        else            w_next = ST_RESP;
      end
      ST_WB:     if (w_l2_xfer) w_next = w_rw ? ST_FILL : ST_RESP;
      ST_FILL:   if (w_l2_xfer) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= '0;
      r_line     <= '0;
      r_sweep    <= '0;
      r_way      <= '0;
      r_l2_addr  <= '0;
      r_resp_hit <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: r_sweep <= r_sweep + 1'b1;
        ST_IDLE: if (w_accept) begin
          r_cmd      <= req_cmd;
          r_line     <= req_addr[ADDR_W-1:OFFSET_BITS];
          r_resp_hit <= 1'b0;
          r_sweep    <= '0;
        end
        ST_LOOKUP: begin
          r_resp_hit <= w_hit;
          if (w_rw && !w_hit) begin
            r_way     <= w_victim;
            r_l2_addr <= w_victim_dirty ? {r_tag[w_index][w_victim], w_index} : r_line;
          end else if (!w_rw && w_hit) begin
            r_way     <= w_hit_way;
            r_l2_addr <= r_line;
          end
        end
        ST_WB:   if (w_l2_xfer) r_l2_addr <= r_line;
        default: ;
      endcase
    end
  end

  // NOTE: tag/state arrays are deliberately not reset; the CLEAR sweep initialises them.
  always_ff @(posedge clk) begin
    case (r_state)
      ST_CLEAR: begin
        r_valid[r_sweep] <= '0;
        r_dirty[r_sweep] <= '0;
        r_age[r_sweep]   <= w_init_age;
        for (int w = 0; w < WAYS; w++) r_tag[r_sweep][w] <= '0;
      end
      ST_LOOKUP: if (w_hit) begin
        if (w_rw) begin
          r_age[w_index] <= w_new_age;
          if (r_cmd == CMD_WRITE) r_dirty[w_index][w_hit_way] <= 1'b1;
        end else if (!w_hit_dirty) begin
          r_valid[w_index][w_hit_way] <= 1'b0;
        end
      end
      ST_WB: if (w_l2_xfer && !w_rw) begin
        r_valid[w_index][r_way] <= 1'b0;
        r_dirty[w_index][r_way] <= 1'b0;
      end
      ST_FILL: if (w_l2_xfer) begin
        r_tag[w_index][r_way]   <= w_tag;
        r_valid[w_index][r_way] <= 1'b1;
        r_dirty[w_index][r_way] <= (r_cmd == CMD_WRITE);
        r_age[w_index]          <= w_new_age;
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt, r_read_cnt, r_write_cnt, r_wb_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || (w_accept && (req_cmd == CMD_CLEAR))) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
      r_wb_cnt    <= '0;
    end else begin
      if ((r_state == ST_LOOKUP) && w_rw) begin
        if (r_cmd == CMD_READ) r_read_cnt  <= sat_inc(r_read_cnt);
        else                   r_write_cnt <= sat_inc(r_write_cnt);
        if (w_hit)             r_hit_cnt   <= sat_inc(r_hit_cnt);
        else                   r_miss_cnt  <= sat_inc(r_miss_cnt);
      end
      if ((r_state == ST_WB) && w_l2_xfer) r_wb_cnt <= sat_inc(r_wb_cnt);
    end
  end

  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign read_cnt  = r_read_cnt;
  assign write_cnt = r_write_cnt;
  assign wb_cnt    = r_wb_cnt;
`else
  assign hit_cnt   = '0;
  assign miss_cnt  = '0;
  assign read_cnt  = '0;
  assign write_cnt = '0;
  assign wb_cnt    = '0;
`endif

endmodule

// File: tb/tb_dcache_sa_wb.sv
// Directed scoreboard bench for dcache_sa_wb (64 sets, 4 ways, 64-byte lines).
module tb_dcache_sa_wb;
  import dcache_pkg::*;

  localparam int INDEX_BITS = 6;
  localparam int SETS       = 2 ** INDEX_BITS;
  localparam int LINE_W     = 26;
  localparam int WAIT_MAX   = SETS + 40;

  logic              clk = 1'b0;
  logic              rst_n, req_valid, req_ready, resp_valid, resp_hit;
  logic              l2_valid, l2_ready, l2_wb, busy;
  logic [3:0]        req_cmd;
  logic [31:0]       req_addr;
  logic [LINE_W-1:0] l2_addr;
  logic [31:0]       hit_cnt, miss_cnt, read_cnt, write_cnt, wb_cnt;

  typedef struct packed {
    logic              wb;
    logic [LINE_W-1:0] addr;
  } l2_t;

  l2_t  q_l2[$];
  logic q_resp[$];
  int   n_checks = 0;
  int   n_errors = 0;

  dcache_sa_wb #(.INDEX_BITS(INDEX_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .l2_valid(l2_valid), .l2_ready(l2_ready), .l2_wb(l2_wb), .l2_addr(l2_addr), .busy(busy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .read_cnt(read_cnt), .write_cnt(write_cnt),
    .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int tag, input int idx);
    return 32'((tag << 12) | (idx << 6));
  endfunction

  function automatic logic [LINE_W-1:0] ln(input int tag, input int idx);
    return LINE_W'((tag << 6) | idx);
  endfunction

  function automatic logic [31:0] ec(input int v);
`ifdef DCACHE_STATS_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic push_l2(input logic wb, input logic [LINE_W-1:0] addr);
    l2_t e;
    e.wb = wb;
    e.addr = addr;
    q_l2.push_back(e);
  endtask

  task automatic check_cnt(input string tag, input int h, input int m, input int r, input int w, input int b);
    check({tag, "_hit_cnt"},   hit_cnt,   ec(h));
    check({tag, "_miss_cnt"},  miss_cnt,  ec(m));
    check({tag, "_read_cnt"},  read_cnt,  ec(r));
    check({tag, "_write_cnt"}, write_cnt, ec(w));
    check({tag, "_wb_cnt"},    wb_cnt,    ec(b));
  endtask

  // Counts negedges until req_ready is seen high (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge: drives a command, waits for acceptance, then serves l2
  // requests against q_l2 and compares the response against q_resp.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] addr, input logic exp_hit,
                       output int lat);
    int   n;
    logic done;
    l2_t  e;
    logic h;
    q_resp.push_back(exp_hit);
    req_cmd = cmd;
    req_addr = addr;
    req_valid = 1'b1;
    wait_ready(n);
    check("accept_seen", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    done = 1'b0;
    while (!done && lat < WAIT_MAX) begin
      @(negedge clk);
      lat++;
      if (l2_valid) begin
        if (q_l2.size() == 0) begin
          check("l2_unexpected", {l2_wb, l2_addr}, 0);
        end else begin
          e = q_l2.pop_front();
          check("l2_wb", l2_wb, e.wb);
          check("l2_addr", l2_addr, e.addr);
        end
      end
      if (resp_valid) begin
        done = 1'b1;
        h = q_resp.pop_front();
        check("resp_hit", resp_hit, h);
      end
    end
    check("resp_seen", done, 1'b1);
    check("l2_all_issued", q_l2.size(), 0);
    q_l2.delete();
    q_resp.delete();
  endtask

  initial begin
    int n, lat, stable;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_cmd = CMD_READ;
    req_addr = '0;
    l2_ready = 1'b1;

    // Reset values, then sweep length with req_valid held.
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_l2_valid", l2_valid, 1'b0);
    check("rst_l2_addr", l2_addr, 0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check_cnt("rst", 0, 0, 0, 0, 0);
    req_cmd = 4'd2;
    req_valid = 1'b1;
    rst_n = 1'b1;
    wait_ready(n);
    check("sweep_len", n, SETS);
    check("idle_busy", busy, 1'b0);
    check_cnt("swept", 0, 0, 0, 0, 0);
    issue(4'd2, 32'h0, 1'b0, lat);
    check("ignored_lat", lat, 1);
    check_cnt("ignored", 0, 0, 0, 0, 0);

    // READ miss then hit on 0x1040.
    push_l2(1'b0, 26'h41);
    issue(CMD_READ, 32'h0000_1040, 1'b0, lat);
    issue(CMD_READ, 32'h0000_1040, 1'b1, lat);
    check("hit_latency", lat, 2);
    check_cnt("read2", 1, 1, 2, 0, 0);

    // Five WRITE tags in set 0: the fifth evicts the first (dirty) line.
    for (int t = 0; t < 4; t++) begin
      push_l2(1'b0, ln(16 + t, 0));
      issue(CMD_WRITE, mk(16 + t, 0), 1'b0, lat);
    end
    push_l2(1'b1, ln(16, 0));
    push_l2(1'b0, ln(20, 0));
    issue(CMD_WRITE, mk(20, 0), 1'b0, lat);
    check_cnt("evict", 1, 6, 2, 5, 1);

    // LRU order in set 2: fill ways 0..3, touch way 0, new tag evicts way 1.
    for (int t = 0; t < 4; t++) begin
      push_l2(1'b0, ln(32 + t, 2));
      issue(CMD_WRITE, mk(32 + t, 2), 1'b0, lat);
    end
    issue(CMD_WRITE, mk(32, 2), 1'b1, lat);
    push_l2(1'b1, ln(33, 2));
    push_l2(1'b0, ln(36, 2));
    issue(CMD_READ, mk(36, 2), 1'b0, lat);
    issue(CMD_READ, mk(32, 2), 1'b1, lat);
    push_l2(1'b1, ln(34, 2));
    push_l2(1'b0, ln(33, 2));
    issue(CMD_READ, mk(33, 2), 1'b0, lat);
    check_cnt("lru", 3, 12, 5, 10, 3);

    // INVALIDATE: dirty hit writes back, absent tag and clean hit issue no l2 request.
    push_l2(1'b1, ln(35, 2));
    issue(CMD_INVAL, mk(35, 2), 1'b1, lat);
    push_l2(1'b0, ln(35, 2));
    issue(CMD_READ, mk(35, 2), 1'b0, lat);
    issue(CMD_INVAL, mk(85, 2), 1'b0, lat);
    issue(CMD_INVAL, mk(36, 2), 1'b1, lat);
    push_l2(1'b0, ln(36, 2));
    issue(CMD_READ, mk(36, 2), 1'b0, lat);
    check_cnt("inval", 3, 14, 7, 10, 4);

    // CLEAR command: counters zero at accept, full sweep, previous hit now misses.
    req_cmd = CMD_CLEAR;
    req_addr = '0;
    req_valid = 1'b1;
    wait_ready(n);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_cnt("clear", 0, 0, 0, 0, 0);
    wait_ready(n);
    check("clear_sweep_len", n, SETS);
    push_l2(1'b0, 26'h41);
    issue(CMD_READ, 32'h0000_1040, 1'b0, lat);
    check_cnt("post_clear", 0, 1, 1, 0, 0);

    // Stall FILL for 10 cycles, then reset mid-transfer.
    l2_ready = 1'b0;
    req_cmd = CMD_READ;
    req_addr = mk(48, 3);
    req_valid = 1'b1;
    wait_ready(n);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!l2_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_l2_valid", l2_valid, 1'b1);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (l2_valid && !l2_wb && (l2_addr == ln(48, 3)) && busy && !resp_valid) stable++;
    end
    check("stall_stable", stable, 10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_l2_valid", l2_valid, 1'b0);
    check("mid_rst_l2_addr", l2_addr, 0);
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_req_ready", req_ready, 1'b0);
    @(negedge clk);
    l2_ready = 1'b1;
    rst_n = 1'b1;
    check_cnt("mid_rst", 0, 0, 0, 0, 0);
    wait_ready(n);
    check("rst_sweep_len", n, SETS);
    push_l2(1'b0, 26'h41);
    issue(CMD_READ, 32'h0000_1040, 1'b0, lat);
    push_l2(1'b0, ln(48, 3));
    issue(CMD_READ, mk(48, 3), 1'b0, lat);
    check_cnt("final", 0, 2, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
